int_source_ctrl: RTL

Interrupt source controller that generates the two-bit `interrupt` level vector consumed by the CPU pipeline's CP0 cause field. It provides a programmable periodic timer and a synchronized, debounced external button source. Each source has a sticky pending latch, held until software-driven clear pulses arrive from the board-level glue. It sits outside the pipeline, between board I/O and the pipeline's `interrupt` input, on the same divided CPU clock.

---
 rtl/int_pkg.sv | 14 +
 rtl/int_debounce.sv | 52 +++++
 rtl/int_source_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
// Module  : int_pkg
// Brief   : Shared interrupt source indices and widths.
// Revision: 1.0
// ============================================================================
package int_pkg;
    localparam int INT_EXT   = 0;
    localparam int INT_TIMER = 1;
    localparam int INT_NUM   = 2;
    // Wide enough for the largest legal DEB_CYCLES (65535)
    localparam int DEB_CNT_W = 16;
endpackage
`default_nettype wire

// File: rtl/int_debounce.sv
`default_nettype none
// ============================================================================
// Module  : int_debounce
// Brief   : Two-flop synchronizer plus stability debouncer with rise pulse.
// Revision: 1.0
// ============================================================================
module int_debounce
    import int_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic rise
);
    localparam logic [DEB_CNT_W-1:0] c_LAST = DEB_CNT_W'(DEB_CYCLES - 1);
    localparam logic [DEB_CNT_W-1:0] c_INC  = DEB_CNT_W'(1);

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_level;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic                 w_diff;
    logic                 w_accept;

    assign w_diff   = r_s2 ^ r_level;
    assign w_accept = w_diff && (r_cnt == c_LAST);
    // Fires on the same edge the level flips high, so the top latches it there
    assign rise     = w_accept && r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
            if (w_accept) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + c_INC;
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/int_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : int_source_ctrl
// Brief   : Periodic timer and debounced button feeding sticky CP0 interrupts.
// Revision: 1.0
// ============================================================================
module int_source_ctrl
    import int_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int TMR_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    input  logic               tmr_en,
    input  logic               tmr_load_we,
    input  logic [TMR_W-1:0]   tmr_period,
    input  logic [INT_NUM-1:0] int_clr,
    output logic [INT_NUM-1:0] interrupt,
    output logic [INT_NUM-1:0] int_overrun,
    output logic [TMR_W-1:0]   tmr_count
);
    localparam logic [TMR_W-1:0] c_ONE = TMR_W'(1);

    logic                 w_ext_rise;
    logic                 w_tmr_fire;
    logic [INT_NUM-1:0]   w_evt;
    logic [TMR_W-1:0]     r_period;
    logic [TMR_W-1:0]     r_count;
    logic [INT_NUM-1:0]   r_pend;
    logic [INT_NUM-1:0]   r_ovr;

    int_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .rise   (w_ext_rise)
    );

    // A load suppresses any event on its own cycle
    assign w_tmr_fire = !tmr_load_we && tmr_en && (r_period != '0) && (r_count == c_ONE);

    always_comb begin
        w_evt            = '0;
        w_evt[INT_EXT]   = w_ext_rise;
        w_evt[INT_TIMER] = w_tmr_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= '0;
            r_count  <= '0;
        end else if (tmr_load_we) begin
            r_period <= tmr_period;
            r_count  <= tmr_period;
        end else if (w_tmr_fire) begin
            r_count <= r_period;
        end else if (tmr_en && (r_count > c_ONE)) begin
            r_count <= r_count - c_ONE;
        end
    end

    // Set beats clear; a coincident clear still wipes the overrun history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_ovr  <= '0;
        end else begin
            for (int i = 0; i < INT_NUM; i++) begin
                if (w_evt[i]) begin
                    r_pend[i] <= 1'b1;
                    r_ovr[i]  <= !int_clr[i] && (r_ovr[i] || r_pend[i]);
                end else if (int_clr[i]) begin
                    r_pend[i] <= 1'b0;
                    r_ovr[i]  <= 1'b0;
                end
            end
        end
    end

    assign interrupt   = r_pend;
    assign int_overrun = r_ovr;
    assign tmr_count   = r_count;
endmodule
`default_nettype wire
